// File: rtl/add_share_arbiter.sv
// Two-requester front end for one shared N-bit carry-bypass adder.
// Whole transactions are granted round-robin, carries chain across words and results return registered.
module add_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_first,
  input  logic         req0_last,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_first,
  input  logic         req1_last,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_of,
  output logic         rsp_last
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t       state_r, state_nxt_s;
  logic         owner_r, owner_nxt_s;
  logic         prio_r, prio_nxt_s;
  logic         creg_r;
  logic         gid_s, accept_s;
  logic [N-1:0] a_s, b_s;
  logic         cin_raw_s, first_s, last_s, cin_s;
  logic [N:0]   add_s;
  logic         of_s;

  // Ripple inside 4-bit blocks; a fully propagating block passes its carry-in straight through.
  function automatic logic [N:0] cb_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic cin);
    logic [N-1:0] s;
    logic         c, cblk, pblk;
    c    = cin;
    cblk = cin;
    pblk = 1'b1;
    s    = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      pblk = pblk & (a[i] ^ b[i]);
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      if (((i % 4) == 3) || (i == N - 1)) begin
        if (pblk) c = cblk;
        else      c = c;
        cblk = c;
        pblk = 1'b1;
      end
    end
    return {c, s};
  endfunction

  // Grant and ready: depends only on state, owner, prio and the valids.
  always_comb begin
    gid_s      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst) begin
      gid_s = 1'b0;
    end else if (state_r == IDLE) begin
      if (req0_valid && req1_valid) gid_s = prio_r;
      else                          gid_s = req1_valid;
      req0_ready = req0_valid & ~gid_s;
      req1_ready = req1_valid & gid_s;
    end else begin
      gid_s      = owner_r;
      req0_ready = req0_valid & ~owner_r;
      req1_ready = req1_valid & owner_r;
    end
  end

  assign accept_s = req0_ready | req1_ready;

  // Operand mux and carry-in selection for the granted requester.
  always_comb begin
    case (gid_s)
      1'b1: begin
        a_s = req1_a; b_s = req1_b; cin_raw_s = req1_cin;
        first_s = req1_first; last_s = req1_last;
      end
      default: begin
        a_s = req0_a; b_s = req0_b; cin_raw_s = req0_cin;
        first_s = req0_first; last_s = req0_last;
      end
    endcase
    if ((state_r == IDLE) || first_s) cin_s = cin_raw_s;
    else                              cin_s = creg_r;
  end

  assign add_s = cb_add(a_s, b_s, cin_s);
  assign of_s  = ~(a_s[N-1] ^ b_s[N-1]) & (add_s[N-1] ^ a_s[N-1]);

  // Next-state: a last word releases the lock and hands priority to the other side.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    prio_nxt_s  = prio_r;
    if (accept_s) begin
      if (last_s) begin
        state_nxt_s = IDLE;
        prio_nxt_s  = ~gid_s;
      end else begin
        state_nxt_s = LOCKED;
        owner_nxt_s = gid_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, carry and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      prio_r    <= 1'b0;
      creg_r    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_of    <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      owner_r   <= owner_nxt_s;
      prio_r    <= prio_nxt_s;
      rsp_valid <= accept_s;
      if (accept_s) begin
        creg_r   <= add_s[N];
        rsp_id   <= gid_s;
        rsp_sum  <= add_s[N-1:0];
        rsp_cout <= add_s[N];
        rsp_of   <= of_s;
        rsp_last <= last_s;
      end
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: a reference arbiter/adder model predicts
// ready each cycle and queues the expected response for the following cycle.
module tb_add_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req0_first, req0_last;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_first, req1_last;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_cout, rsp_of, rsp_last;
  logic [31:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        cout;
    logic        of;
    logic        last;
  } rsp_t;
  rsp_t sb[$];

  // reference model state
  logic m_locked = 1'b0, m_owner = 1'b0, m_prio = 1'b0, m_creg = 1'b0;

  always #5 clk = ~clk;

  add_share_arbiter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_first(req0_first), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_first(req1_first), .req1_last(req1_last),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_of(rsp_of), .rsp_last(rsp_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic first, input logic last);
    req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_first = first; req0_last = last;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic first, input logic last);
    req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_first = first; req1_last = last;
  endtask

  // One clock: predict/check ready, push expectation, clock, pop/check response.
  task automatic step();
    logic        gid, r0, r1, acc, cin, first, last;
    logic [31:0] a, b;
    logic [32:0] full;
    rsp_t        e;
    #1;
    gid = 1'b0; r0 = 1'b0; r1 = 1'b0;
    if (!rst) begin
      if (m_locked) gid = m_owner;
      else if (req0_valid && req1_valid) gid = m_prio;
      else gid = req1_valid;
      r0 = req0_valid && (gid == 1'b0);
      r1 = req1_valid && (gid == 1'b1);
    end
    acc = r0 || r1;
    check_eq("req0_ready", {63'd0, req0_ready}, {63'd0, r0});
    check_eq("req1_ready", {63'd0, req1_ready}, {63'd0, r1});
    if (gid) begin a = req1_a; b = req1_b; cin = req1_cin; first = req1_first; last = req1_last; end
    else     begin a = req0_a; b = req0_b; cin = req0_cin; first = req0_first; last = req0_last; end
    if (m_locked && !first) cin = m_creg;
    full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.id   = gid;
    e.sum  = full[31:0];
    e.cout = full[32];
    e.of   = (a[31] == b[31]) && (full[31] != a[31]);
    e.last = last;
    if (acc) sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_locked = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_creg = 1'b0;
    end else if (acc) begin
      m_creg = full[32];
      if (last) begin m_locked = 1'b0; m_prio = ~gid; end
      else begin m_locked = 1'b1; m_owner = gid; end
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
      check_eq("rsp_sum", {32'd0, rsp_sum}, {32'd0, e.sum});
      check_eq("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
      check_eq("rsp_last", {63'd0, rsp_last}, {63'd0, e.last});
      if (e.last) check_eq("rsp_of", {63'd0, rsp_of}, {63'd0, e.of});
    end else begin
      check_eq("rsp_valid_idle", {63'd0, rsp_valid}, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b1, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1);
    set1(1'b1, 32'h3, 32'h4, 1'b0, 1'b1, 1'b1);
    step(); step();
    check_eq("reset_rsp_sum", {32'd0, rsp_sum}, 64'd0);
    check_eq("reset_rsp_flags", {59'd0, rsp_id, rsp_cout, rsp_of, rsp_last, rsp_valid}, 64'd0);
    rst = 1'b0;
    set0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // single-word wrap-around add
    set0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("single_sum", {32'd0, rsp_sum}, 64'd0);
    check_eq("single_cout_of", {62'd0, rsp_cout, rsp_of}, 64'd2);
    set0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // 64-bit chained add by requester 1
    set1(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("chain_w0_sum", {32'd0, rsp_sum}, 64'd0);
    set1(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("chain_w1_sum", {32'd0, rsp_sum}, 64'd1);
    check_eq("chain_w1_cout", {63'd0, rsp_cout}, 64'd0);

    // lock: req0 3-word chain while req1 stays valid
    set1(1'b1, 32'h10, 32'h20, 1'b0, 1'b1, 1'b1);
    set0(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    step();
    set0(1'b1, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
    step();
    set0(1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1);
    step();
    set0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("lock_then_req1", {63'd0, rsp_id}, 64'd1);
    set1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // round-robin from reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'b1, 1'b1);
      set1(1'b1, $urandom, $urandom, 1'($urandom_range(1)), 1'b1, 1'b1);
      step();
      check_eq("rr_order", {63'd0, rsp_id}, 64'(i % 2));
    end
    set1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // signed overflow cases
    set0(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("of_pos", {29'd0, rsp_sum, rsp_of, rsp_cout}, {29'd0, 32'h8000_0000, 1'b1, 1'b0});
    set0(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("of_neg", {29'd0, rsp_sum, rsp_of, rsp_cout}, {29'd0, 32'h0, 1'b1, 1'b1});

    // reset mid-chain: req1's first word must use its own cin, not the stale carry
    set0(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    set0(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    set0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set1(1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("rst_mid_sum", {32'd0, rsp_sum}, 64'd2);
    check_eq("rst_mid_id", {63'd0, rsp_id}, 64'd1);

    // random traffic including restarts within a lock and stalled owners
    for (int i = 0; i < 300; i++) begin
      set0(1'($urandom_range(1)), $urandom, (i % 3 == 0) ? ~req0_a : $urandom,
           1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
      set1(1'($urandom_range(1)), $urandom, $urandom,
           1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
      rst = ($urandom_range(60) == 0);
      step();
    end
    rst = 1'b0;
    set0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Shares a single N-bit carry-bypass adder datapath between two requesters, one word per cycle, with per-transaction carry chaining so each requester can perform multi-word (k×N-bit) additions. A round-robin arbiter grants whole transactions, locks the adder to the owner until its last word is accepted, and returns registered results tagged with the requester id. The block sits in front of the shared adder and is the only path requesters use to reach it.

## Interface
- N, 32, word width of operands and sum (N ≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 presents a word
- req0_ready  out  1  word accepted this cycle when valid & ready
- req0_a, req0_b  in  N  operands
- req0_cin  in  1  carry-in, used on the first word of a transaction
- req0_first  in  1  word is the first of a transaction
- req0_last  in  1  word is the last of a transaction (first & last = single-word add)
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_first, req1_last: same as requester 0
- rsp_valid  out  1  result valid, one-cycle pulse per accepted word, no backpressure
- rsp_id  out  1  requester that issued the word
- rsp_sum  out  N  sum word
- rsp_cout  out  1  carry-out of the word
- rsp_of  out  1  signed overflow of the word, meaningful on the last word only
- rsp_last  out  1  copy of the accepted word's last flag

## Operation
- States: IDLE, LOCKED (plus an owner register, 1 bit); round-robin pointer prio (1 bit); carry register creg (1 bit).
- IDLE grant: only one valid → that requester; both valid → requester prio. Granted requester sees ready=1 combinationally in the same cycle; the other sees ready=0.
- LOCKED: only the owner gets ready=1 (whenever it is valid); the other requester is held off regardless of prio.
- On accept: if last=0 → LOCKED with owner=granted id; if last=1 → IDLE and prio ← the non-granted id (single-word transactions also rotate priority).
- Carry-in selection: IDLE → reqX_cin (first flag ignored, every IDLE accept starts a transaction); LOCKED & first=1 → reqX_cin (owner restarts its chain, lock retained); LOCKED & first=0 → creg.
- creg ← cout of every accepted word.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^N for sum; of = ~(a[N-1]^b[N-1]) & (sum[N-1]^a[N-1]).
- Owner dropping valid while LOCKED: lock and creg are held indefinitely; no timeout.
- No accept → creg, state, owner and prio unchanged.

## Timing
- Reset values: state IDLE, owner 0, prio 0 (requester 0 favoured), creg 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, rsp_of 0, rsp_last 0; req*_ready = 0 while rst is high.
- Latency: word accepted at edge t → rsp_* valid for the cycle after edge t (rsp registered, 1-cycle latency); rsp_valid deasserts the following cycle unless another word is accepted.
- Throughput: one word per cycle sustained, including back-to-back chained words (creg feeds cin in the next cycle) and back-to-back transactions from alternating requesters.
- Ready is combinational from state, owner, prio and the valids only, never from operand data.
- rst asserted mid-chain: lock dropped, creg cleared, any response of the word accepted in that cycle is discarded (rsp_valid = 0 next cycle).

## Test plan
- Single-word add, N=32: req0 a=0xFFFFFFFF, b=0x00000001, cin=0, first=last=1 → next cycle rsp_valid=1, id=0, sum=0x00000000, cout=1, of=0, last=1.
- Chained 64-bit add by req1: word0 a=0xFFFFFFFF, b=1, cin=0, first=1, last=0; word1 a=0, b=0, first=0, last=1 → rsp sums 0x00000000 (cout=1) then 0x00000001 (cout=0), consecutive cycles.
- Lock: req0 starts 3-word chain while req1 valid continuously → req1_ready=0 until req0's last word accepted; req1 granted the following cycle.
- Round-robin: both valid with single-word adds every cycle → grants alternate 0,1,0,1 starting from requester 0 after reset.
- Overflow: a=0x7FFFFFFF, b=0x00000001, cin=0, single word → sum=0x80000000, of=1, cout=0; a=0x80000000, b=0x80000000 → sum=0, of=1, cout=1.
- Reset mid-chain: rst after word0 of a req0 chain (cout=1) → state IDLE, req1 granted next, its first word uses req1_cin (not creg).
